// File: rtl/inst_prefetch_q_pkg.sv
// Shared definitions for the Thumb-2 instruction prefetch queue.
// Holds the 32-bit prefix patterns and the queue FSM state encoding.
package inst_prefetch_q_pkg;

    // hw[15:11] values that mark the first halfword of a 32-bit encoding
    localparam logic [4:0] PFX_T32_A = 5'b11101;
    localparam logic [4:0] PFX_T32_B = 5'b11110;
    localparam logic [4:0] PFX_T32_C = 5'b11111;

    typedef enum logic {
        RUN     = 1'b0,
        SKIP_HW = 1'b1
    } ipq_state_e;

endpackage

// File: rtl/inst_prefetch_q_if.sv
// Fetch-side and pre-decode-side handshake bundle of the prefetch queue.
// master: fetch source + consumer side; slave: the queue itself.
interface inst_prefetch_q_if #(
    parameter int FETCH_W = 32
);
    logic [FETCH_W-1:0] fetch_data;
    logic               fetch_valid;
    logic               fetch_ready;
    logic               flush;
    logic [31:0]        flush_pc;
    logic [31:0]        inst;
    logic               inst_is32;
    logic [31:0]        inst_pc;
    logic               inst_valid;
    logic               inst_ready;

    modport master (
        output fetch_data, fetch_valid, flush, flush_pc, inst_ready,
        input  fetch_ready, inst, inst_is32, inst_pc, inst_valid
    );

    modport slave (
        input  fetch_data, fetch_valid, flush, flush_pc, inst_ready,
        output fetch_ready, inst, inst_is32, inst_pc, inst_valid
    );
endinterface

// File: rtl/inst_prefetch_q_thumb_len_dec.sv
// Thumb-2 length decoder: flags a halfword that starts a 32-bit encoding.
// Ports: hw (in, 16) halfword; is32 (out, 1) 32-bit prefix detected.
module thumb_len_dec
    import inst_prefetch_q_pkg::*;
(
    input  logic [15:0] hw,
    output logic        is32
);
    always_comb begin
        is32 = 1'b0;
        case (hw[15:11])
            PFX_T32_A, PFX_T32_B, PFX_T32_C: is32 = 1'b1;
            default:                         is32 = 1'b0;
        endcase
    end
endmodule

// File: rtl/inst_prefetch_q.sv
// Thumb-2 prefetch queue: buffers fetch beats as halfwords and hands
// complete 16/32-bit instructions with their PC to pre-decode.
// Ports: clk, rst (async, active-low), bus (inst_prefetch_q_if.slave).
// Optional IPQ_PERF_CNT_EN adds perf_stall_cnt[31:0], perf_flush_cnt[15:0].
module inst_prefetch_q
    import inst_prefetch_q_pkg::*;
#(
    parameter int          FETCH_W  = 32,
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    inst_prefetch_q_if.slave bus
`ifdef IPQ_PERF_CNT_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [15:0]      perf_flush_cnt
`endif
);
    localparam int HPB = FETCH_W / 16;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [CW-1:0] count, pop_n, push_n;
    ipq_state_e    state;
    logic          run, first;
    logic [15:0]   hw0, hw1;
    logic          head32, complete, load, fire;
    logic [31:0]   inst_q, pc_q;
    logic          is32_q, valid_q;

    assign rd_nxt = rd_ptr + PW'(1);
    assign hw0    = mem[rd_ptr];
    assign hw1    = mem[rd_nxt];

    thumb_len_dec u_len (
        .hw   (hw0),
        .is32 (head32)
    );

    // a lone prefix halfword is never presented
    assign complete = head32 ? (count >= CW'(2)) : (count != '0);
    assign load     = (!valid_q || bus.inst_ready) && complete && !bus.flush;

    // run keeps fetch_ready low until the first edge after reset
    assign bus.fetch_ready = run && (count <= CW'(DEPTH - HPB)) && !bus.flush;
    assign fire            = bus.fetch_valid && bus.fetch_ready;

    assign pop_n  = !load ? '0 : (head32 ? CW'(2) : CW'(1));
    assign push_n = !fire ? '0 :
                    (state == SKIP_HW) ? CW'(1) : CW'(HPB);

    assign bus.inst       = inst_q;
    assign bus.inst_is32  = is32_q;
    assign bus.inst_pc    = pc_q;
    assign bus.inst_valid = valid_q;

    always_ff @(posedge clk) begin
        if (fire) begin
            if (state == SKIP_HW) begin
                // redirect into the upper halfword: drop hw0
                mem[wr_ptr] <= bus.fetch_data[FETCH_W-1 -: 16];
            end else begin
                for (int k = 0; k < HPB; k++) begin
                    mem[wr_ptr + PW'(k)] <= bus.fetch_data[16*k +: 16];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            state   <= RUN;
            run     <= 1'b0;
            first   <= 1'b1;
            inst_q  <= '0;
            is32_q  <= 1'b0;
            pc_q    <= RESET_PC & ~32'h1;
            valid_q <= 1'b0;
        end else begin
            run <= 1'b1;
            if (bus.flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                valid_q <= 1'b0;
                first   <= 1'b1;
                pc_q    <= bus.flush_pc & ~32'h1;
                state   <= (HPB == 2 && bus.flush_pc[1]) ? SKIP_HW : RUN;
            end else begin
                count  <= count + push_n - pop_n;
                rd_ptr <= rd_ptr + pop_n[PW-1:0];
                wr_ptr <= wr_ptr + push_n[PW-1:0];
                if (fire) begin
                    state <= RUN;
                end
                if (load) begin
                    valid_q <= 1'b1;
                    first   <= 1'b0;
                    is32_q  <= head32;
                    inst_q  <= head32 ? {hw0, hw1} : {16'h0, hw0};
                    // first load after a redirect sits at the target itself
                    if (!first) begin
                        pc_q <= pc_q + (is32_q ? 32'd4 : 32'd2);
                    end
                end else if (bus.inst_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

`ifdef IPQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (bus.inst_ready && !valid_q && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (bus.flush && perf_flush_cnt != '1) begin
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_q.sv
// Bench for inst_prefetch_q: halfword/address queue model checked
// every cycle, plus directed vectors with literal expectations.
module tb_inst_prefetch_q;
    localparam int          FW    = 32;
    localparam int          DEPTH = 4;
    localparam int          HPB   = FW / 16;
    localparam logic [31:0] RPC   = 32'h0000_0081;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    inst_prefetch_q_if #(.FETCH_W(FW)) bus ();
`ifdef IPQ_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    inst_prefetch_q #(
        .FETCH_W  (FW),
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IPQ_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: halfwords not yet loaded, each tagged with its address
    logic [15:0] hq[$];
    logic [31:0] aq[$];
    logic        m_run, m_skip, m_ov, m_o32;
    logic [31:0] m_oi, m_opc, m_addr, m_stall;
    logic [15:0] m_fl;

    function automatic logic pfx(logic [15:0] h);
        return h[15:11] >= 5'b11101;
    endfunction

    always @(negedge clk) begin : model
        logic fr;
        if (!rst) begin
            hq.delete();
            aq.delete();
            m_run   = 1'b0;
            m_skip  = 1'b0;
            m_ov    = 1'b0;
            m_o32   = 1'b0;
            m_oi    = '0;
            m_opc   = RPC & ~32'h1;
            m_addr  = RPC & ~32'h1;
            m_stall = '0;
            m_fl    = '0;
        end else begin
            fr = m_run && (hq.size() <= DEPTH - HPB) && !bus.flush;
            chk("fetch_ready", 32'(bus.fetch_ready), 32'(fr));
            chk("inst_valid", 32'(bus.inst_valid), 32'(m_ov));
            chk("inst_pc", bus.inst_pc, m_opc);
            if (m_ov) begin
                chk("inst", bus.inst, m_oi);
                chk("inst_is32", 32'(bus.inst_is32), 32'(m_o32));
            end
`ifdef IPQ_PERF_CNT_EN
            chk("perf_stall", perf_stall_cnt, m_stall);
            chk("perf_flush", 32'(perf_flush_cnt), 32'(m_fl));
`endif
            tests++;
            assert (dut.count <= DEPTH) else begin
                fails++;
                $display("FAIL count_bound: got %0d want <= %0d", dut.count, DEPTH);
            end
            if (bus.inst_ready && !m_ov) m_stall++;
            if (bus.flush) begin
                m_fl++;
                hq.delete();
                aq.delete();
                m_ov   = 1'b0;
                m_opc  = bus.flush_pc & ~32'h1;
                m_addr = bus.flush_pc & ~32'h1;
                m_skip = (HPB == 2) && bus.flush_pc[1];
            end else begin
                if ((!m_ov || bus.inst_ready) && hq.size() >= 1 &&
                    (!pfx(hq[0]) || hq.size() >= 2)) begin
                    m_o32 = pfx(hq[0]);
                    m_opc = aq[0];
                    m_oi  = m_o32 ? {hq[0], hq[1]} : {16'h0, hq[0]};
                    void'(hq.pop_front());
                    void'(aq.pop_front());
                    if (m_o32) begin
                        void'(hq.pop_front());
                        void'(aq.pop_front());
                    end
                    m_ov = 1'b1;
                end else if (bus.inst_ready) begin
                    m_ov = 1'b0;
                end
                if (bus.fetch_valid && fr) begin
                    if (m_skip) begin
                        hq.push_back(bus.fetch_data[31:16]);
                        aq.push_back(m_addr);
                        m_addr += 2;
                        m_skip = 1'b0;
                    end else begin
                        for (int k = 0; k < HPB; k++) begin
                            hq.push_back(bus.fetch_data[16*k +: 16]);
                            aq.push_back(m_addr);
                            m_addr += 2;
                        end
                    end
                end
            end
            m_run = 1'b1;
        end
    end

    task automatic drive(logic fv, logic [31:0] fd, logic fl,
                         logic [31:0] fpc, logic rdy);
        bus.fetch_valid = fv;
        bus.fetch_data  = fd;
        bus.flush       = fl;
        bus.flush_pc    = fpc;
        bus.inst_ready  = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(logic fv, logic [31:0] fd, logic fl,
                       logic [31:0] fpc, logic rdy);
        drive(fv, fd, fl, fpc, rdy);
        step();
    endtask

    task automatic beat(logic [31:0] fd, logic rdy);
        int   n;
        logic acc;
        n = 0;
        do begin
            drive(1'b1, fd, 1'b0, '0, rdy);
            #1;
            acc = bus.fetch_ready;
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: beat %h not accepted in %0d cycles", fd, n);
        end
        drive(1'b0, '0, 1'b0, '0, rdy);
    endtask

    initial begin : stim
        int n;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_is32", 32'(bus.inst_is32), 32'h0);
        chk("rst_pc", bus.inst_pc, 32'h80);
        chk("rst_fready", 32'(bus.fetch_ready), 32'h0);
        rst = 1'b1;
        #1;
        chk("rel_fready_low", 32'(bus.fetch_ready), 32'h0);
        step();
        chk("rel_fready_high", 32'(bus.fetch_ready), 32'h1);

        // two beats, prefix waits for the next beat
        cyc(1'b0, '0, 1'b1, 32'h100, 1'b1);
        beat(32'h4601_2000, 1'b1);
        beat(32'hF000_BF00, 1'b1);
        chk("a_valid", 32'(bus.inst_valid), 32'h1);
        chk("a_inst0", bus.inst, 32'h0000_2000);
        chk("a_pc0", bus.inst_pc, 32'h100);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        chk("a_inst1", bus.inst, 32'h0000_4601);
        chk("a_pc1", bus.inst_pc, 32'h102);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        chk("a_inst2", bus.inst, 32'h0000_BF00);
        chk("a_pc2", bus.inst_pc, 32'h104);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        chk("a_prefix_held", 32'(bus.inst_valid), 32'h0);
        beat(32'h2001_F800, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        chk("a_inst32", bus.inst, 32'hF000_F800);
        chk("a_is32", 32'(bus.inst_is32), 32'h1);
        chk("a_pc32", bus.inst_pc, 32'h106);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        chk("a_after32_pc", bus.inst_pc, 32'h10A);

        // odd-halfword redirect, then a 32-bit inst across the wrap
        cyc(1'b0, '0, 1'b1, 32'h102, 1'b1);
        beat(32'h1111_2222, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        chk("b_valid", 32'(bus.inst_valid), 32'h1);
        chk("b_inst", bus.inst, 32'h0000_1111);
        chk("b_pc", bus.inst_pc, 32'h102);
        beat(32'h3333_2222, 1'b1);
        beat(32'hFFFE_F7FF, 1'b1);
        n = 0;
        while (!(bus.inst_valid && bus.inst_is32) && n < 10) begin
            cyc(1'b0, '0, 1'b0, '0, 1'b1);
            n++;
        end
        chk("b_wrap_inst", bus.inst, 32'hF7FF_FFFE);
        chk("b_wrap_pc", bus.inst_pc, 32'h108);

        // fill with consumer stalled, hold, then drain
        cyc(1'b0, '0, 1'b1, 32'h200, 1'b0);
        beat(32'h2002_2001, 1'b0);
        beat(32'h2004_2003, 1'b0);
        drive(1'b1, 32'h2006_2005, 1'b0, '0, 1'b0);
        repeat (10) step();
        chk("c_full_fready", 32'(bus.fetch_ready), 32'h0);
        chk("c_hold_inst", bus.inst, 32'h0000_2001);
        chk("c_hold_pc", bus.inst_pc, 32'h200);
        beat(32'h2006_2005, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, 1'b0);
        chk("d_pre_valid", 32'(bus.inst_valid), 32'h1);

        // flush beats a beat, a load and a consume in the same cycle
        cyc(1'b1, 32'hAAAA_BBBB, 1'b1, 32'h300, 1'b1);
        chk("d_valid", 32'(bus.inst_valid), 32'h0);
        chk("d_pc", bus.inst_pc, 32'h300);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        chk("d_dropped", 32'(bus.inst_valid), 32'h0);

        // asynchronous reset in the middle of a stream
        cyc(1'b0, '0, 1'b1, 32'h400, 1'b0);
        beat(32'h2222_1111, 1'b0);
        cyc(1'b0, '0, 1'b0, '0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("e_valid", 32'(bus.inst_valid), 32'h0);
        chk("e_inst", bus.inst, 32'h0);
        chk("e_is32", 32'(bus.inst_is32), 32'h0);
        chk("e_pc", bus.inst_pc, 32'h80);
        chk("e_fready", 32'(bus.fetch_ready), 32'h0);
`ifdef IPQ_PERF_CNT_EN
        chk("e_perf_stall", perf_stall_cnt, 32'h0);
        chk("e_perf_flush", 32'(perf_flush_cnt), 32'h0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;

        // starved consumer and three flush pulses
        repeat (5) cyc(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (3) begin
            cyc(1'b0, '0, 1'b1, 32'h500, 1'b1);
            cyc(1'b0, '0, 1'b0, '0, 1'b1);
        end
`ifdef IPQ_PERF_CNT_EN
        chk("f_perf_flush", 32'(perf_flush_cnt), 32'h3);
        chk("f_perf_stall_ge5", 32'(perf_stall_cnt >= 32'd5), 32'h1);
`endif
        beat(32'hF123_4567, 1'b1);
        beat(32'h0000_E800, 1'b1);
        repeat (4) cyc(1'b0, '0, 1'b0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
